// File: rtl/seven_segment_pkg.sv
// Shared constants and types for the multiplexed four-digit seven-segment scanner.
package seven_segment_pkg;

   localparam int unsigned NUM_DIGITS       = 4;
   localparam int unsigned NIBBLE_W         = 4;
   localparam int unsigned DATA_W           = NUM_DIGITS * NIBBLE_W;
   localparam int unsigned SEG_W            = 8;
   localparam int unsigned HEX_SEG_W        = 7;
   localparam int unsigned COUNT_MAX_DEF    = 100000;
   localparam int unsigned BLANK_CYCLES_DEF = 8;

   typedef logic [1:0] digit_idx_t;

   // Frame snapshot of the display request inputs
   typedef struct packed {
      logic [DATA_W-1:0]     data;
      logic [NUM_DIGITS-1:0] dp;
      logic [NUM_DIGITS-1:0] blank;
   } shadow_t;

   localparam shadow_t SHADOW_RST = '{data: '0, dp: '0, blank: '1};

endpackage

// File: rtl/seven_segment.sv
// Active-low hex-to-seven-segment decode; segment[0]=CA .. segment[6]=CG.
module seven_segment
   import seven_segment_pkg::*;
(
   input  logic [NIBBLE_W-1:0]  data,
   output logic [HEX_SEG_W-1:0] segment
);

   always_comb begin
      segment = '1;
      case (data)
         4'h0: segment = 7'h40;
         4'h1: segment = 7'h79;
         4'h2: segment = 7'h24;
         4'h3: segment = 7'h30;
         4'h4: segment = 7'h19;
         4'h5: segment = 7'h12;
         4'h6: segment = 7'h02;
         4'h7: segment = 7'h78;
         4'h8: segment = 7'h00;
         4'h9: segment = 7'h10;
         4'hA: segment = 7'h08;
         4'hB: segment = 7'h03;
         4'hC: segment = 7'h46;
         4'hD: segment = 7'h21;
         4'hE: segment = 7'h06;
         4'hF: segment = 7'h0E;
         default: segment = '1;
      endcase
   end

endmodule

// File: rtl/seven_segment_scan.sv
// Time-multiplexed four-digit scanner with per-frame input snapshot, dead-time
// at the start of each digit slot, and registered anode/segment/frame_tick pins.
module seven_segment_scan
   import seven_segment_pkg::*;
#(
   parameter int unsigned COUNT_MAX    = COUNT_MAX_DEF,
   parameter int unsigned BLANK_CYCLES = BLANK_CYCLES_DEF
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [DATA_W-1:0]     data,
   input  logic [NUM_DIGITS-1:0] dp_in,
   input  logic [NUM_DIGITS-1:0] blank,
   output logic [SEG_W-1:0]      segment,
   output logic [NUM_DIGITS-1:0] anode,
   output logic                  frame_tick
);

   localparam int unsigned      CNT_W      = (COUNT_MAX > 1) ? $clog2(COUNT_MAX) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(COUNT_MAX - 1);
   localparam logic [CNT_W-1:0] CNT_BLANK  = CNT_W'(BLANK_CYCLES);
   localparam digit_idx_t       DIGIT_LAST = digit_idx_t'(NUM_DIGITS - 1);

   logic [CNT_W-1:0]      cnt_q, cnt_d;
   digit_idx_t            digit_q, digit_d;
   shadow_t               shadow_q, shadow_d;
   logic                  load_pending_q, load_pending_d;
   logic [NUM_DIGITS-1:0] anode_q, anode_d;
   logic [SEG_W-1:0]      segment_q, segment_d;
   logic                  frame_tick_q, frame_tick_d;

   logic                  slot_end;
   logic                  capture;
   logic                  drive;
   logic [NIBBLE_W-1:0]   nibble;
   logic [HEX_SEG_W-1:0]  hex_seg;

   assign nibble = shadow_q.data[{digit_q, 2'b00} +: NIBBLE_W];

   seven_segment u_decode (
      .data    (nibble),
      .segment (hex_seg)
   );

   // Next-state for scan position, snapshot and pin values
   always_comb begin
      cnt_d          = cnt_q + CNT_W'(1);
      digit_d        = digit_q;
      shadow_d       = shadow_q;
      load_pending_d = 1'b0;
      anode_d        = '1;
      segment_d      = '1;

      slot_end = (cnt_q == CNT_LAST);
      capture  = load_pending_q || (slot_end && (digit_q == DIGIT_LAST));
      drive    = (cnt_q >= CNT_BLANK) && !shadow_q.blank[digit_q];

      if (slot_end) begin
         cnt_d   = '0;
         digit_d = digit_q + digit_idx_t'(1);
      end

      if (capture) begin
         shadow_d = '{data: data, dp: dp_in, blank: blank};
      end

      if (drive) begin
         anode_d[digit_q] = 1'b0;
         segment_d        = {~shadow_q.dp[digit_q], hex_seg};
      end

      frame_tick_d = capture;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt_q          <= '0;
         digit_q        <= '0;
         shadow_q       <= SHADOW_RST;
         load_pending_q <= 1'b1;
         anode_q        <= '1;
         segment_q      <= '1;
         frame_tick_q   <= 1'b0;
      end else begin
         cnt_q          <= cnt_d;
         digit_q        <= digit_d;
         shadow_q       <= shadow_d;
         load_pending_q <= load_pending_d;
         anode_q        <= anode_d;
         segment_q      <= segment_d;
         frame_tick_q   <= frame_tick_d;
      end
   end

   assign anode      = anode_q;
   assign segment    = segment_q;
   assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_seven_segment_scan.sv
// Directed bench for seven_segment_scan with COUNT_MAX=8, BLANK_CYCLES=2.
module tb_seven_segment_scan;

   localparam int unsigned CM = 8;
   localparam int unsigned BC = 2;

   logic        clk;
   logic        rst_n;
   logic [15:0] data;
   logic [3:0]  dp_in;
   logic [3:0]  blank;
   logic [7:0]  segment;
   logic [3:0]  anode;
   logic        frame_tick;

   int n_cmp = 0;
   int n_err = 0;

   seven_segment_scan #(
      .COUNT_MAX    (CM),
      .BLANK_CYCLES (BC)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .data       (data),
      .dp_in      (dp_in),
      .blank      (blank),
      .segment    (segment),
      .anode      (anode),
      .frame_tick (frame_tick)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Advance one clock, sample just after the edge, and check at most one anode is low
   task automatic tick(input string tag);
      logic ok;
      @(posedge clk);
      #1;
      ok = $onehot0(~anode);
      chk($sformatf("%s onehot", tag), {7'd0, ok}, 8'd1);
   endtask

   // One full digit slot; ft_phase is the slot cycle where frame_tick must be high (-1: none)
   task automatic run_slot(input string frame, input int d, input logic [3:0] an,
                           input logic [7:0] seg, input int ft_phase);
      string tag;
      for (int p = 0; p < int'(CM); p++) begin
         tag = $sformatf("%s d%0d p%0d", frame, d, p);
         tick(tag);
         if (p < int'(BC)) begin
            chk({tag, " anode"}, {4'd0, anode}, 8'h0F);
            chk({tag, " seg"}, segment, 8'hFF);
         end else begin
            chk({tag, " anode"}, {4'd0, anode}, {4'd0, an});
            chk({tag, " seg"}, segment, seg);
         end
         chk({tag, " ftick"}, {7'd0, frame_tick}, (p == ft_phase) ? 8'd1 : 8'd0);
      end
   endtask

   initial begin
      rst_n = 1'b0;
      data  = 16'h1234;
      dp_in = 4'h0;
      blank = 4'h0;

      for (int i = 0; i < 3; i++) begin
         tick($sformatf("rst%0d", i));
         chk($sformatf("rst%0d anode", i), {4'd0, anode}, 8'h0F);
         chk($sformatf("rst%0d seg", i), segment, 8'hFF);
         chk($sformatf("rst%0d ftick", i), {7'd0, frame_tick}, 8'd0);
      end

      // Frame 1: first capture at release, shows 1234
      rst_n = 1'b1;
      run_slot("f1", 0, 4'b1110, 8'h99, 0);
      run_slot("f1", 1, 4'b1101, 8'hB0, -1);
      run_slot("f1", 2, 4'b1011, 8'hA4, -1);
      run_slot("f1", 3, 4'b0111, 8'hF9, 7);

      // Frame 2: data changes in digit-1 slot, not visible this frame
      run_slot("f2", 0, 4'b1110, 8'h99, -1);
      data = 16'hABCD;
      run_slot("f2", 1, 4'b1101, 8'hB0, -1);
      run_slot("f2", 2, 4'b1011, 8'hA4, -1);
      run_slot("f2", 3, 4'b0111, 8'hF9, 7);

      // Frame 3: ABCD visible; blank request queued for next frame
      blank = 4'b0100;
      run_slot("f3", 0, 4'b1110, 8'hA1, -1);
      run_slot("f3", 1, 4'b1101, 8'hC6, -1);
      run_slot("f3", 2, 4'b1011, 8'h83, -1);
      run_slot("f3", 3, 4'b0111, 8'h88, 7);

      // Frame 4: digit 2 blanked; dp request queued
      dp_in = 4'b1000;
      blank = 4'b0000;
      run_slot("f4", 0, 4'b1110, 8'hA1, -1);
      run_slot("f4", 1, 4'b1101, 8'hC6, -1);
      run_slot("f4", 2, 4'b1111, 8'hFF, -1);
      run_slot("f4", 3, 4'b0111, 8'h88, 7);

      // Frame 5: decimal point only on digit 3
      run_slot("f5", 0, 4'b1110, 8'hA1, -1);
      run_slot("f5", 1, 4'b1101, 8'hC6, -1);
      run_slot("f5", 2, 4'b1011, 8'h83, -1);
      run_slot("f5", 3, 4'b0111, 8'h08, 7);

      // Frame 6: reset pulse inside the digit-2 slot
      run_slot("f6", 0, 4'b1110, 8'hA1, -1);
      run_slot("f6", 1, 4'b1101, 8'hC6, -1);
      for (int p = 0; p < 3; p++) begin
         tick($sformatf("f6 d2 p%0d", p));
         chk($sformatf("f6 d2 p%0d anode", p), {4'd0, anode}, (p < 2) ? 8'h0F : 8'h0B);
         chk($sformatf("f6 d2 p%0d seg", p), segment, (p < 2) ? 8'hFF : 8'h83);
         chk($sformatf("f6 d2 p%0d ftick", p), {7'd0, frame_tick}, 8'd0);
      end
      rst_n = 1'b0;
      data  = 16'h5678;
      tick("midrst");
      chk("midrst anode", {4'd0, anode}, 8'h0F);
      chk("midrst seg", segment, 8'hFF);
      chk("midrst ftick", {7'd0, frame_tick}, 8'd0);
      rst_n = 1'b1;

      // Frame 7: restart from digit 0 with a fresh snapshot
      run_slot("f7", 0, 4'b1110, 8'h80, 0);
      run_slot("f7", 1, 4'b1101, 8'hF8, -1);
      run_slot("f7", 2, 4'b1011, 8'h82, -1);
      run_slot("f7", 3, 4'b0111, 8'h12, 7);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
